// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM generator and capture blocks:
// duty-code scale and the capture FSM state encoding.
`timescale 1ns/1ps
package pwm_pkg;

    localparam int DUTY_W    = 10;
    localparam int DUTY_FULL = 1024;
    localparam int DUTY_MAX  = 1023;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } pwm_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing the 11-bit duty quotient floor(num*1024/den).
// One quotient bit per cycle; q is valid in the cycle done is high.
`timescale 1ns/1ps
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [DUTY_W:0]  q
);

    localparam int QBITS = DUTY_W + 1;

    logic [CNT_W:0]    rem;
    logic [CNT_W-1:0]  den_r;
    logic [DUTY_W-1:0] q_r;
    logic [3:0]        step;
    logic              ge;
    logic [CNT_W-1:0]  diff;

    // Remainder stays below den after each subtract, so the shifted value fits CNT_W+1 bits.
    always_comb begin
        ge   = (rem >= {1'b0, den_r});
        diff = ge ? CNT_W'(rem - {1'b0, den_r}) : rem[CNT_W-1:0];
        q    = {q_r, ge};
        done = busy && (step == 4'(QBITS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            step <= '0;
        end else if (busy) begin
            step <= step + 4'd1;
            if (done)
                busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            step <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!busy && start) begin
            rem   <= {1'b0, num};
            den_r <= den;
            q_r   <= '0;
        end else if (busy) begin
            rem   <= {diff, 1'b0};
            q_r   <= q[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles,
// converts to a 10-bit duty code and flags stuck and too-fast inputs.
`timescale 1ns/1ps
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int MIN_PERIOD     = 16,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck_high,
    output logic              stuck_low,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= TO_LIM) ? TO_LIM : v + ONE;
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W:0] q);
        return q[DUTY_W] ? DUTY_W'(DUTY_MAX) : q[DUTY_W-1:0];
    endfunction

    pwm_state_t       state, state_next;
    logic [CNT_W-1:0] per_cnt, per_next;
    logic [CNT_W-1:0] hi_cnt, hi_next;
    logic [CNT_W-1:0] cap_period, cap_high;
    logic             pwm_p0, pwm_p1, pwm_p2;
    logic             rise, fall;
    logic             start, short_period, timeout;
    logic             div_busy, div_done;
    logic [DUTY_W:0]  div_q;

    // Stage p0/p1: two-flop synchronizer; p2: registered copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_p0 <= 1'b0;
            pwm_p1 <= 1'b0;
            pwm_p2 <= 1'b0;
        end else begin
            pwm_p0 <= pwm_in;
            pwm_p1 <= pwm_p0;
            pwm_p2 <= pwm_p1;
        end
    end

    assign rise = pwm_p1 & ~pwm_p2;
    assign fall = ~pwm_p1 & pwm_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            state   <= state_next;
            per_cnt <= per_next;
            hi_cnt  <= hi_next;
        end
    end

    // In IDLE per_cnt doubles as the timeout timer; it is held while a stuck flag is up
    // so a permanently stuck input reports once rather than every timeout interval.
    always_comb begin
        state_next   = state;
        per_next     = per_cnt;
        hi_next      = hi_cnt;
        start        = 1'b0;
        short_period = 1'b0;
        timeout      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            per_next   = '0;
            hi_next    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hi_next = '0;
                    if (rise) begin
                        state_next = HIGH;
                        per_next   = ONE;
                        hi_next    = ONE;
                    end else if (fall || stuck_high || stuck_low) begin
                        per_next = '0;
                    end else if (per_cnt >= TO_LIM) begin
                        timeout  = 1'b1;
                        per_next = '0;
                    end else begin
                        per_next = sat_inc(per_cnt);
                    end
                end
                HIGH: begin
                    per_next = sat_inc(per_cnt);
                    hi_next  = pwm_p1 ? sat_inc(hi_cnt) : hi_cnt;
                    if (fall) begin
                        state_next = LOW;
                    end else if (per_cnt >= TO_LIM) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                        per_next   = '0;
                        hi_next    = '0;
                    end
                end
                LOW: begin
                    per_next = sat_inc(per_cnt);
                    hi_next  = pwm_p1 ? sat_inc(hi_cnt) : hi_cnt;
                    if (rise) begin
                        state_next = HIGH;
                        per_next   = ONE;
                        hi_next    = ONE;
                        if (per_cnt < MIN_LIM)
                            short_period = 1'b1;
                        else
                            start = !div_busy;
                    end else if (per_cnt >= TO_LIM) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                        per_next   = '0;
                        hi_next    = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            cap_period <= per_cnt;
            cap_high   <= hi_cnt;
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .num   (hi_cnt),
        .den   (per_cnt),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    // Output stage: results publish together with the valid pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period     <= '0;
            high_time  <= '0;
            duty       <= '0;
            valid      <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (timeout) begin
                    valid     <= 1'b1;
                    period    <= '0;
                    high_time <= '0;
                    if (pwm_p1) begin
                        stuck_high <= 1'b1;
                        duty       <= DUTY_W'(DUTY_MAX);
                    end else begin
                        stuck_low  <= 1'b1;
                        duty       <= '0;
                    end
                end else if (div_done) begin
                    valid     <= 1'b1;
                    period    <= cap_period;
                    high_time <= cap_high;
                    duty      <= clamp_duty(div_q);
                end
                if (rise)
                    stuck_low <= 1'b0;
                if (fall)
                    stuck_high <= 1'b0;
                if (short_period)
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a shortened timeout so stuck cases stay brief.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int CNT_W = 32;
    localparam int TO    = 5000;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [9:0]       duty;
    logic             valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int vcount = 0;
    int vlast_cyc = 0;
    int vprev_cyc = 0;
    int rise_cyc = 0;
    int base = 0;

    pwm_capture #(
        .TIMEOUT_CYCLES (TO),
        .MIN_PERIOD     (16),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty       (duty),
        .valid      (valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vprev_cyc = vlast_cyc;
            vlast_cyc = cyc;
            vcount    = vcount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a rising clk edge; each period starts with the high phase.
    task automatic drive_pwm(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in   = 1'b1;
            rise_cyc = cyc;
            repeat (hi) @(posedge clk);
            #1;
            pwm_in = 1'b0;
            repeat (per - hi) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_enable();
        enable = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
    endtask

    // Latency from driving pwm_in high after edge n: synced value reads 1 in cycle n+2 (E),
    // results appear in E+12, so valid is seen after edge n+14.
    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_flags", {29'd0, stuck_high, stuck_low, overrun}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;

        // 100 MHz / 25 kHz generator output, duty code 800
        base = vcount;
        drive_pwm(4001, 3125, 3);
        check("gen_nvalid", 32'(vcount - base), 2);
        check("gen_period", period, 4001);
        check("gen_high", high_time, 3125);
        check("gen_duty", 32'(duty), 799);
        check("gen_interval", 32'(vlast_cyc - vprev_cyc), 4001);
        check("gen_latency", 32'(vlast_cyc - rise_cyc), 14);

        pulse_enable();
        base = vcount;
        drive_pwm(1024, 512, 2);
        check("half_nvalid", 32'(vcount - base), 1);
        check("half_period", period, 1024);
        check("half_duty", 32'(duty), 512);

        pulse_enable();
        base = vcount;
        drive_pwm(100, 99, 2);
        check("near_full_high", high_time, 99);
        check("near_full_duty", 32'(duty), 1013);

        // Shortest accepted period
        pulse_enable();
        base = vcount;
        drive_pwm(16, 8, 2);
        check("min_nvalid", 32'(vcount - base), 1);
        check("min_period", period, 16);
        check("min_duty", 32'(duty), 512);
        check("min_overrun", 32'(overrun), 0);

        pulse_enable();
        base = vcount;
        drive_pwm(15, 7, 2);
        check("p15_overrun", 32'(overrun), 1);
        check("p15_nvalid", 32'(vcount - base), 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("p15_clear", 32'(overrun), 0);
        enable = 1'b1;

        base = vcount;
        drive_pwm(10, 5, 3);
        check("p10_overrun", 32'(overrun), 1);
        check("p10_nvalid", 32'(vcount - base), 0);
        check("p10_period_hold", period, 16);
        check("p10_duty_hold", 32'(duty), 512);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("p10_clear", 32'(overrun), 0);
        enable = 1'b1;

        // Reset during a division (cycle E+5 of the capturing edge)
        drive_pwm(4001, 3125, 1);
        base     = vcount;
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rdiv_period", period, 0);
        check("rdiv_duty", 32'(duty), 0);
        pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rdiv_nvalid", 32'(vcount - base), 0);
        check("rdiv_high", high_time, 0);
        base = vcount;
        drive_pwm(4001, 3125, 2);
        check("rdiv_resume_nvalid", 32'(vcount - base), 1);
        check("rdiv_resume_duty", 32'(duty), 799);
        check("rdiv_resume_latency", 32'(vlast_cyc - rise_cyc), 14);

        // Stuck high: timeout valid at E+TO+1 = drive edge + TO + 3
        pulse_enable();
        base     = vcount;
        pwm_in   = 1'b1;
        rise_cyc = cyc;
        repeat (TO + 100) @(posedge clk);
        #1;
        check("sh_flag", 32'(stuck_high), 1);
        check("sh_duty", 32'(duty), 1023);
        check("sh_period", period, 0);
        check("sh_high", high_time, 0);
        check("sh_nvalid", 32'(vcount - base), 1);
        check("sh_when", 32'(vlast_cyc - rise_cyc), TO + 3);
        repeat (TO + 100) @(posedge clk);
        #1;
        check("sh_single_valid", 32'(vcount - base), 1);
        check("sh_hold", 32'(stuck_high), 1);
        pwm_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("sh_clear", 32'(stuck_high), 0);
        drive_pwm(1024, 256, 3);
        check("sh_resume_nvalid", 32'(vcount - base), 3);
        check("sh_resume_duty", 32'(duty), 256);
        check("sh_resume_period", period, 1024);

        // Stuck low straight after reset
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = vcount;
        repeat (TO + 100) @(posedge clk);
        #1;
        check("sl_flag", 32'(stuck_low), 1);
        check("sl_other", 32'(stuck_high), 0);
        check("sl_duty", 32'(duty), 0);
        check("sl_period", period, 0);
        check("sl_nvalid", 32'(vcount - base), 1);
        pwm_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("sl_clear", 32'(stuck_low), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
